// File: rtl/determ_mult_seq_pkg.sv
// Shared types and width helpers for the deterministic bipolar stream multiplier.
package determ_mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned stream_len(input int unsigned width);
    return 32'd1 << width;
  endfunction

  function automatic int unsigned ones_width(input int unsigned width);
    return 2 * width + 1;
  endfunction

  function automatic int unsigned prod_width(input int unsigned width);
    return 2 * width + 2;
  endfunction

endpackage

// File: rtl/determ_mult_lane.sv
// One multiplier lane: latched operand codes, unary comparators, XNOR product
// stream, ones counter and the registered signed bipolar product.
module determ_mult_lane
  import determ_mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 load,
  input  logic                 run,
  input  logic                 fin,
  input  logic [WIDTH-1:0]     a_val,
  input  logic [WIDTH-1:0]     b_val,
  input  logic [WIDTH-1:0]     i,
  input  logic [WIDTH-1:0]     j,
  output logic                 y_c,
  output logic [2*WIDTH+1:0]   prod
);

  localparam int unsigned OW = ones_width(WIDTH);
  localparam int unsigned PW = prod_width(WIDTH);
  localparam int unsigned LL = stream_len(WIDTH) * stream_len(WIDTH);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OW-1:0]    ones_q;
  logic [OW-1:0]    ones_d;

  // Unary streams: A sweeps per i, B holds per j, so A cycles once per B bit.
  always_comb begin
    y_c    = run & ~((i < a_q) ^ (j < b_q));
    ones_d = ones_q + OW'(y_c);
  end

  // prod captures the final count including the last stream bit.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      a_q    <= '0;
      b_q    <= '0;
      ones_q <= '0;
      prod   <= '0;
    end else if (load) begin
      a_q    <= a_val;
      b_q    <= b_val;
      ones_q <= '0;
      prod   <= '0;
    end else if (run) begin
      ones_q <= ones_d;
      if (fin) begin
        prod <= PW'({ones_d, 1'b0}) - PW'(LL);
      end
    end
  end

endmodule

// File: rtl/determ_mult_seq.sv
// Exact sequential multiplier for deterministic bipolar bitstreams: one shared
// sequencer (FSM plus i/j counters) driving CHANNELS independent lanes.
module determ_mult_seq
  import determ_mult_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 1
) (
  input  logic                            CLK,
  input  logic                            nRST,
  input  logic                            start,
  input  logic [CHANNELS*WIDTH-1:0]       a_val,
  input  logic [CHANNELS*WIDTH-1:0]       b_val,
  output logic                            ready,
  output logic [CHANNELS-1:0]             y,
  output logic                            y_valid,
  output logic                            done,
  output logic [CHANNELS*(2*WIDTH+2)-1:0] prod
);

  localparam int unsigned PW = prod_width(WIDTH);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] i_q;
  logic [WIDTH-1:0] j_q;
  logic             last_c;
  logic             load;
  logic             run;
  logic             fin;

  assign last_c = (&i_q) & (&j_q);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    y_valid = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    run     = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        run     = 1'b1;
        y_valid = 1'b1;
        if (last_c) begin
          fin     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // i sweeps the A stream every cycle; j advances once per full A sweep.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      i_q <= '0;
      j_q <= '0;
    end else if (load) begin
      i_q <= '0;
      j_q <= '0;
    end else if (run) begin
      i_q <= i_q + WIDTH'(1);
      if (&i_q) begin
        j_q <= j_q + WIDTH'(1);
      end
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
    determ_mult_lane #(.WIDTH(WIDTH)) u_lane (
      .CLK   (CLK),
      .nRST  (nRST),
      .load  (load),
      .run   (run),
      .fin   (fin),
      .a_val (a_val[n*WIDTH +: WIDTH]),
      .b_val (b_val[n*WIDTH +: WIDTH]),
      .i     (i_q),
      .j     (j_q),
      .y_c   (y[n]),
      .prod  (prod[n*PW +: PW])
    );
  end

endmodule

// File: tb/tb_determ_mult_seq.sv
// Directed bench for determ_mult_seq with WIDTH=2 (L=4) and three lanes.
module tb_determ_mult_seq;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        start;
  logic [5:0]  a_val;
  logic [5:0]  b_val;
  logic        ready;
  logic [2:0]  y;
  logic        y_valid;
  logic        done;
  logic [17:0] prod;

  int errors = 0;
  int checks = 0;
  int ones_cnt[3];

  determ_mult_seq #(.WIDTH(2), .CHANNELS(3)) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .start   (start),
    .a_val   (a_val),
    .b_val   (b_val),
    .ready   (ready),
    .y       (y),
    .y_valid (y_valid),
    .done    (done),
    .prod    (prod)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Runs one operation from IDLE and returns in the DONE cycle.
  task automatic run_op(input string tag, input logic [5:0] av, input logic [5:0] bv,
                        input logic [17:0] ep, input logic [14:0] eo, input bit poke);
    int n;
    int vcnt;
    a_val = av;
    b_val = bv;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, " ready_low"}, 32'(ready), 32'd0);
    check({tag, " prod_cleared"}, 32'(prod), 32'd0);
    n = 0;
    vcnt = 0;
    for (int k = 0; k < 3; k++) ones_cnt[k] = 0;
    while (!done && n < 40) begin
      if (y_valid) begin
        vcnt++;
        for (int k = 0; k < 3; k++) ones_cnt[k] += int'(y[k]);
      end
      start = poke && (n == 5);
      if (poke && n == 5) begin
        a_val = ~av;
        b_val = ~bv;
      end
      step();
      n++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(n), 32'd16);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " valid_cycles"}, 32'(vcnt), 32'd16);
    check({tag, " prod"}, 32'(prod), 32'(ep));
    check({tag, " ones0"}, 32'(ones_cnt[0]), 32'(eo[4:0]));
    check({tag, " ones1"}, 32'(ones_cnt[1]), 32'(eo[9:5]));
    check({tag, " ones2"}, 32'(ones_cnt[2]), 32'(eo[14:10]));
  endtask

  initial begin
    nRST  = 1'b0;
    start = 1'b0;
    a_val = '0;
    b_val = '0;
    #12;
    check("rst ready", 32'(ready), 32'd1);
    check("rst y_valid", 32'(y_valid), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst y", 32'(y), 32'd0);
    check("rst prod", 32'(prod), 32'd0);
    nRST = 1'b1;
    step();

    // Lanes (0,0),(2,2),(3,0): prods +16, 0, -8; ones 16, 8, 4.
    run_op("run1", 6'b11_10_00, 6'b00_10_00, {6'h38, 6'h00, 6'h10},
           {5'd4, 5'd8, 5'd16}, 1'b0);
    step();
    check("run1 idle ready", 32'(ready), 32'd1);
    check("run1 idle done", 32'(done), 32'd0);
    check("run1 idle y", 32'(y), 32'd0);
    check("run1 prod held", 32'(prod), 32'({6'h38, 6'h00, 6'h10}));

    // Lanes (3,3),(2,2),(0,0) with start pulsed mid-run and in DONE.
    run_op("run2", 6'b00_10_11, 6'b00_10_11, {6'h10, 6'h00, 6'h04},
           {5'd16, 5'd8, 5'd10}, 1'b1);
    a_val = 6'b01_01_01;
    b_val = 6'b10_10_10;
    start = 1'b1;
    step();
    start = 1'b0;
    check("run2 ready_after_done", 32'(ready), 32'd1);
    check("run2 no_restart", 32'(y_valid), 32'd0);
    check("run2 prod kept", 32'(prod), 32'({6'h10, 6'h00, 6'h04}));

    // Reset asserted in RUN cycle 7 aborts without a done pulse.
    a_val = 6'b11_11_11;
    b_val = 6'b11_11_11;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("abort in_run", 32'(y_valid), 32'd1);
    nRST = 1'b0;
    #1;
    check("abort ready", 32'(ready), 32'd1);
    check("abort y_valid", 32'(y_valid), 32'd0);
    check("abort y", 32'(y), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort prod", 32'(prod), 32'd0);
    step();
    check("abort no_done", 32'(done), 32'd0);
    nRST = 1'b1;
    step();

    // Lanes (3,0),(3,3),(0,0): prods -8, +4, +16; ones 4, 10, 16.
    run_op("run3", 6'b00_11_11, 6'b00_11_00, {6'h10, 6'h04, 6'h38},
           {5'd16, 5'd10, 5'd4}, 1'b0);
    step();
    check("run3 prod held", 32'(prod), 32'({6'h10, 6'h04, 6'h38}));
    check("run3 ready", 32'(ready), 32'd1);

    // Back-to-back start in the first IDLE cycle after DONE.
    run_op("run4", 6'b11_10_00, 6'b00_10_00, {6'h38, 6'h00, 6'h10},
           {5'd4, 5'd8, 5'd16}, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
